// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, WIDTH cycles per sum.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sbit;
  logic             cnxt;
  logic             last;

  assign sbit = areg[0] ^ breg[0] ^ carry;
  assign cnxt = (areg[0] & breg[0]) | (areg[0] & carry) | (breg[0] & carry);
  assign last = (cnt == CW'(WIDTH - 1));

  // The final sum bit lands in the result register on the same edge that leaves SHIFT.
  always_comb begin
    sreg_nxt            = sreg >> 1;
    sreg_nxt[WIDTH-1]   = sbit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          sreg  <= sreg_nxt;
          carry <= cnxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= sreg_nxt;
            cout <= cnxt;
`ifdef SERIAL_ADDER_OVF_EN
            // carry still holds the carry into the MSB here
            ovf  <= carry ^ cnxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit and a 1-bit instance share clock and reset.
// Expected results are pushed at issue time and popped by monitors on each done pulse.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp8_t;

  typedef struct packed {
    logic s;
    logic c;
    logic o;
  } exp1_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;
  logic       start1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       cin1 = 1'b0;
  logic       busy1;
  logic       done1;
  logic       sum1;
  logic       cout1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8;
  logic       ovf1;
`endif

  exp8_t q8[$];
  exp1_t q1[$];
  int    nCmp = 0;
  int    nFail = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected_done8", 1, 0);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        checkOutput("sum8", int'(sum8), int'(e.s));
        checkOutput("cout8", int'(cout8), int'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf8", int'(ovf8), int'(e.o));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        checkOutput("unexpected_done1", 1, 0);
      end else begin
        exp1_t e;
        e = q1.pop_front();
        checkOutput("sum1", int'(sum1), int'(e.s));
        checkOutput("cout1", int'(cout1), int'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf1", int'(ovf1), int'(e.o));
`endif
      end
    end
  end

  // Start is raised just after edge 0 and sampled at edge 1; done must appear after edge 9.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                               input logic [7:0] es, input logic ec, input logic eo,
                               input bit glitch);
    int         busyCnt;
    int         doneEdge;
    int         stable;
    logic [7:0] prevSum;
    busyCnt  = 0;
    doneEdge = 0;
    stable   = 1;
    @(posedge clk);
    #1;
    prevSum = sum8;
    a8      = ta;
    b8      = tb;
    cin8    = tc;
    start8  = 1'b1;
    q8.push_back('{es, ec, eo});
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        start8 = 1'b0;
        a8     = ~ta;
        b8     = ~tb;
        cin8   = ~tc;
      end
      if (glitch && e == 3) begin
        start8 = 1'b1;
        a8     = 8'hFF;
      end
      if (glitch && e == 4) start8 = 1'b0;
      @(negedge clk);
      if (busy8) begin
        busyCnt++;
        if (sum8 !== prevSum) stable = 0;
      end
      if (done8 && doneEdge == 0) doneEdge = e;
    end
    checkOutput("busy_cycles", busyCnt, 8);
    checkOutput("done_edge", doneEdge, 9);
    checkOutput("sum_hold_in_shift", stable, 1);
  endtask

  task automatic applyStimulus1(input logic ta, input logic tb, input logic tc,
                                input logic es, input logic ec, input logic eo);
    @(posedge clk);
    #1;
    a1     = ta;
    b1     = tb;
    cin1   = tc;
    start1 = 1'b1;
    q1.push_back('{es, ec, eo});
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1;
    checkOutput("rst_busy8", int'(busy8), 0);
    checkOutput("rst_done8", int'(done8), 0);
    checkOutput("rst_sum8", int'(sum8), 0);
    checkOutput("rst_cout8", int'(cout8), 0);
    checkOutput("rst_sum1", int'(sum1), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

    // Abort mid-SHIFT: nothing is queued, so any done pulse is flagged by the monitor.
    @(posedge clk);
    #1;
    a8     = 8'h12;
    b8     = 8'h34;
    cin8   = 1'b0;
    start8 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      start8 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy8", int'(busy8), 0);
    checkOutput("abort_done8", int'(done8), 0);
    checkOutput("abort_sum8", int'(sum8), 0);
    checkOutput("abort_cout8", int'(cout8), 0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("abort_ovf8", int'(ovf8), 0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

    applyStimulus1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    repeat (4) @(posedge clk);
    checkOutput("pending8", q8.size(), 0);
    checkOutput("pending1", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
